// File: rtl/div_seq_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: state encodings, handshake levels
// and the default operand width.
package div_seq_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: trial-subtracts the divisor from the
// partial remainder and returns the restored/reduced remainder plus the quotient bit.
module div_step
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff  = rem_i - {1'b0, divisor_i};
        q_o   = ~diff[WIDTH];
        rem_o = diff[WIDTH] ? rem_i[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer beside EX; stalls the pipe until {remainder, quotient}
// is ready. Optional macro DIV_EARLY_EXIT_EN finishes |dividend| < |divisor| in one step.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int unsigned   CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

    div_state_t state, next_state;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH:0]     dividend;
    logic [WIDTH-1:0]     divisor_q;
    logic                 sign1_q, sign2_q;

    logic                 neg1, neg2, div_by_zero, early;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH-1:0]     step_rem;
    logic                 step_q;
    logic [WIDTH-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;
    logic [2*WIDTH-1:0]   result_d;
    logic                 ready_d;

    always_comb begin
        neg1        = signed_i & opdata1_i[WIDTH-1];
        neg2        = signed_i & opdata2_i[WIDTH-1];
        mag1        = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
        mag2        = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
        div_by_zero = (opdata2_i == '0);
`ifdef DIV_EARLY_EXIT_EN
        early       = (mag1 < mag2);
`else
        early       = 1'b0;
`endif
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (dividend[2*WIDTH:WIDTH]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        quo_raw = dividend[WIDTH-1:0];
        rem_raw = dividend[2*WIDTH:WIDTH+1];
        quo_fix = (sign1_q ^ sign2_q) ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix = sign1_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DivFree;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    next_state = div_by_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: next_state = annul_i ? DivFree : DivEnd;
            DivOn: begin
                if (annul_i) begin
                    next_state = DivFree;
                end else if (cnt == CNT_DONE) begin
                    next_state = DivEnd;
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    next_state = DivFree;
                end
            end
            default: next_state = DivFree;
        endcase
    end

    always_comb begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        case (state)
            DivByZero: begin
                if (!annul_i) begin
                    ready_d = DivResultReady;
                end
            end
            DivOn: begin
                if (!annul_i && cnt == CNT_DONE) begin
                    ready_d  = DivResultReady;
                    result_d = {rem_fix, quo_fix};
                end
            end
            DivEnd: begin
                if (start_i == DivStart && !annul_i) begin
                    ready_d  = ready_o;
                    result_d = result_o;
                end
            end
            default: ;
        endcase
    end

    assign stallreq_o = start_i && !ready_o;

    // Early exit preloads a finished dividend (remainder=|op1|, quotient=0) with cnt
    // already at the end, so the normal sign-fix edge restores the original signed op1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dividend  <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            result_o <= result_d;
            ready_o  <= ready_d;
            case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i && !div_by_zero) begin
                        divisor_q <= mag2;
                        sign1_q   <= neg1;
                        sign2_q   <= neg2;
                        if (early) begin
                            dividend <= {mag1, {(WIDTH+1){1'b0}}};
                            cnt      <= CNT_DONE;
                        end else begin
                            dividend <= {{WIDTH{1'b0}}, mag1, 1'b0};
                            cnt      <= '0;
                        end
                    end
                end
                DivOn: begin
                    if (cnt != CNT_DONE) begin
                        dividend <= {step_rem, dividend[WIDTH-1:0], step_q};
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq: a transaction-level reference model
// predicts ready/result every cycle; directed cases pin literal results and latency.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic longint mag(input logic [31:0] x, input logic s);
        longint v;
        v = s ? longint'($signed(x)) : longint'({32'd0, x});
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        if (mag(a, s) < mag(b, s)) return 1;
`endif
        return 33;
    endfunction

    // Transaction-level model: a request turns into "result appears N edges later".
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_pending = 64'd0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_result = 64'd0;
        end else if (m_ready) begin
            if (!start_i || annul_i) begin
                m_ready = 1'b0; m_result = 64'd0;
            end
        end else if (m_busy) begin
            if (annul_i) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_ready = 1'b1; m_result = m_pending;
                end
            end
        end else if (start_i && !annul_i) begin
            m_busy    = 1'b1;
            m_pending = ref_div(opdata1_i, opdata2_i, signed_i);
            m_left    = ref_latency(opdata1_i, opdata2_i, signed_i);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
            chk("cyc_result", result_o, m_result);
            chk("cyc_stall", {63'd0, stallreq_o}, {63'd0, start_i && !m_ready});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat, input string nm);
        int n = 0;
        start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
        do begin
            step(); n++;
            if (n == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~s;
            end
        end while (!ready_o && n < 100);
        chk({nm, "_latency"}, 64'(n), 64'(lat + 1));
        chk({nm, "_result"}, result_o, exp);
        start_i = 1'b0;
        step();
    endtask

    task automatic rand_txn();
        int n = 0;
        int abort_at;
        logic [31:0] a, b;
        logic s;
        a = $urandom; b = $urandom; s = 1'($urandom);
        case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = $urandom_range(1, 20);
            2: a = $urandom_range(0, 50);
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
        endcase
        abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 36) : 0;
        start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
        forever begin
            step(); n++;
            opdata1_i = $urandom; opdata2_i = $urandom;
            if (ready_o) break;
            if (n == abort_at) begin
                annul_i = 1'b1; start_i = 1'b0;
                step();
                annul_i = 1'b0;
                return;
            end
            if (n >= 80) begin
                chk("rand_timeout", 64'd0, 64'd1);
                break;
            end
        end
        start_i = 1'b0;
        step();
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        step();
        chk_en = 1'b1;
        step(); step();
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        step();

        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "div_7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, "div_ovf");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 33, "divu_big");
        run_div(32'd5, 32'd0, 1'b0, 64'd0, 1, "div_by_zero");
`ifdef DIV_EARLY_EXIT_EN
        run_div(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 1, "early_3_10");
        run_div(32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'd0}, 1, "early_m3_10");
`else
        run_div(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 33, "early_3_10");
        run_div(32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'd0}, 33, "early_m3_10");
`endif

        // Abort at iteration 10, then a fresh request must run the full latency.
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (11) step();
        annul_i = 1'b1; start_i = 1'b0;
        step();
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin step(); seen |= ready_o; end
        chk("annul_no_ready", {63'd0, seen}, 64'd0);
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "after_annul_9_3");

        // Annul held in FREE blocks start; releasing it lets the request in.
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        repeat (3) step();
        annul_i = 1'b0;
        run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, "annul_in_free");

        // Reset mid-operation.
        start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (6) step();
        rst = 1'b1; start_i = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_ready", {63'd0, ready_o}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        step();

        repeat (150) rand_txn();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
